// File: rtl/block_stream_gen.sv
// block_stream_gen: expands begin/end/filler word commands into an ASCII
// byte stream and tracks the nesting result a BlockChecker should report.
module block_stream_gen #(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_word,
    input  logic               cmd_upper,
    output logic [7:0]         out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DEPTH_W-1:0] depth,
    output logic               expect_ok
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WORD,
        S_SEP
    } state_e;

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    state_e             state_q, state_d;
    logic [1:0]         word_q, word_d;
    logic               upper_q, upper_d;
    logic [2:0]         idx_q, idx_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;
    logic [7:0]         letter;
    logic               last_letter;

    // Lower-case letter at the current index of the latched word.
    always_comb begin
        letter      = 8'h00;
        last_letter = 1'b1;
        unique case (word_q)
            2'b00: begin
                last_letter = (idx_q == 3'd4);
                case (idx_q)
                    3'd0:    letter = 8'h62;
                    3'd1:    letter = 8'h65;
                    3'd2:    letter = 8'h67;
                    3'd3:    letter = 8'h69;
                    default: letter = 8'h6e;
                endcase
            end
            2'b01: begin
                last_letter = (idx_q == 3'd2);
                case (idx_q)
                    3'd0:    letter = 8'h65;
                    3'd1:    letter = 8'h6e;
                    default: letter = 8'h64;
                endcase
            end
            2'b10: begin
                last_letter = (idx_q == 3'd2);
                case (idx_q)
                    3'd0:    letter = 8'h78;
                    3'd1:    letter = 8'h79;
                    default: letter = 8'h7a;
                endcase
            end
            2'b11: begin
                letter      = 8'h00;
                last_letter = 1'b1;
            end
        endcase
    end

    // Next-state, handshake outputs and nesting commit.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        upper_d   = upper_q;
        idx_d     = idx_q;
        depth_d   = depth_q;
        err_d     = err_q;
        cmd_ready = 1'b0;
        out_valid = 1'b0;
        out       = 8'h00;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
            end
            S_WORD: begin
                out_valid = 1'b1;
                out       = upper_q ? (letter ^ 8'h20) : letter;
                if (out_ready) begin
                    if (last_letter) begin
                        state_d = S_SEP;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_SEP: begin
                out_valid = 1'b1;
                out       = 8'h20;
                cmd_ready = out_ready;
                if (out_ready) begin
                    state_d = S_IDLE;
                    if (word_q == 2'b00) begin
                        if (depth_q != DEPTH_MAX) begin
                            depth_d = depth_q + 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (word_q == 2'b01) begin
                        if (depth_q != '0) begin
                            depth_d = depth_q - 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (cmd_valid && cmd_ready) begin
            word_d  = cmd_word;
            upper_d = cmd_upper;
            idx_d   = 3'd0;
            state_d = (cmd_word == 2'b11) ? S_SEP : S_WORD;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            word_q  <= 2'b00;
            upper_q <= 1'b0;
            idx_q   <= 3'd0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            upper_q <= upper_d;
            idx_q   <= idx_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    assign depth     = depth_q;
    assign expect_ok = (depth_q == '0) && !err_q;

endmodule

// File: tb/tb_block_stream_gen.sv
// tb_block_stream_gen: directed and randomized checks of block_stream_gen
// against a byte-queue reference model, at DEPTH_W=8 and DEPTH_W=2.
module tb_block_stream_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_word = 2'b00;
    logic       cmd_upper = 1'b0;
    logic       out_ready = 1'b0;

    logic       cmd_ready, out_valid, expect_ok;
    logic [7:0] out, depth;
    logic       cmd_ready2, out_valid2, expect_ok2;
    logic [7:0] out2;
    logic [1:0] depth2;

    block_stream_gen #(.DEPTH_W(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_word(cmd_word), .cmd_upper(cmd_upper),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .depth(depth), .expect_ok(expect_ok)
    );

    block_stream_gen #(.DEPTH_W(2)) dut2 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
        .cmd_word(cmd_word), .cmd_upper(cmd_upper),
        .out(out2), .out_valid(out_valid2), .out_ready(out_ready),
        .depth(depth2), .expect_ok(expect_ok2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] b;
        int         act;
    } item_t;

    item_t mq[$];
    int    m_d8, m_d2;
    bit    m_e8, m_e2;

    logic       o_rdy, o_val, o_ok, o_rdy2, o_val2, o_ok2;
    logic [7:0] o_out, o_dep, o_out2;
    logic [1:0] o_dep2;
    logic       e_rdy, e_val, e_ok, e_ok2;
    logic [7:0] e_out, e_dep;
    logic [1:0] e_dep2;

    logic [2:0] cmdq[$];
    logic [7:0] got[$];
    int         got_cyc[$];
    logic [7:0] dep_at[$];
    int         ready_bad, hold_bad;
    bit         timeout;

    function automatic void push_word(input logic [1:0] w, input logic up);
        logic [7:0] s[$];
        item_t it;
        int act;
        act = 0;
        case (w)
            2'b00: begin s = {8'h62, 8'h65, 8'h67, 8'h69, 8'h6e}; act = 1; end
            2'b01: begin s = {8'h65, 8'h6e, 8'h64}; act = 2; end
            2'b10: s = {8'h78, 8'h79, 8'h7a};
            default: s = {};
        endcase
        foreach (s[i]) begin
            it.b = up ? (s[i] ^ 8'h20) : s[i];
            it.act = 0;
            mq.push_back(it);
        end
        it.b = 8'h20;
        it.act = act;
        mq.push_back(it);
    endfunction

    function automatic void commit(input int act);
        if (act == 1) begin
            if (m_d8 < 255) m_d8++; else m_e8 = 1'b1;
            if (m_d2 < 3) m_d2++; else m_e2 = 1'b1;
        end else if (act == 2) begin
            if (m_d8 > 0) m_d8--; else m_e8 = 1'b1;
            if (m_d2 > 0) m_d2--; else m_e2 = 1'b1;
        end
    endfunction

    function automatic string bytes_str();
        string s;
        s = "";
        foreach (got[i]) s = {s, $sformatf("%c", got[i])};
        return s;
    endfunction

    task automatic step(input logic cv, input logic [1:0] w, input logic up,
                        input logic ordy, input logic rst);
        cmd_valid = cv;
        cmd_word  = w;
        cmd_upper = up;
        out_ready = ordy;
        reset     = rst;
        @(negedge clk);
        o_rdy = cmd_ready;   o_val = out_valid;   o_out = out;
        o_dep = depth;       o_ok = expect_ok;
        o_rdy2 = cmd_ready2; o_val2 = out_valid2; o_out2 = out2;
        o_dep2 = depth2;     o_ok2 = expect_ok2;
        e_val  = (mq.size() > 0);
        e_out  = e_val ? mq[0].b : 8'h00;
        e_rdy  = (mq.size() == 0) || (mq.size() == 1 && ordy);
        e_dep  = 8'(m_d8);
        e_ok   = (m_d8 == 0) && !m_e8;
        e_dep2 = 2'(m_d2);
        e_ok2  = (m_d2 == 0) && !m_e2;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_d8 = 0; m_d2 = 0; m_e8 = 1'b0; m_e2 = 1'b0;
        end else begin
            if (e_val && ordy) begin
                commit(mq[0].act);
                void'(mq.pop_front());
            end
            if (cv && e_rdy) push_word(w, up);
        end
        #1;
    endtask

    task automatic run_cmds(input int mode);
        logic [7:0] prev;
        logic [2:0] c;
        logic       ordy, cv;
        bit         prev_stall;
        int         n;
        prev = 8'h00; prev_stall = 1'b0; n = 0;
        got.delete(); got_cyc.delete(); dep_at.delete();
        ready_bad = 0; hold_bad = 0; timeout = 1'b0;
        forever begin
            ordy = (mode == 0) ? 1'b1 : (n % 2 == 0);
            cv   = (cmdq.size() > 0);
            c    = cv ? cmdq[0] : 3'b000;
            step(cv, c[1:0], c[2], ordy, 1'b0);
            if (prev_stall && o_out !== prev) hold_bad++;
            prev_stall = o_val && !ordy;
            prev = o_out;
            if (o_val && o_rdy && o_out != 8'h20) ready_bad++;
            if (o_val && ordy) begin
                got.push_back(o_out);
                got_cyc.push_back(n);
                dep_at.push_back(o_dep);
            end
            n++;
            if (cv && o_rdy) void'(cmdq.pop_front());
            else if (cmdq.size() == 0 && !o_val) break;
            if (n > 200) begin
                timeout = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        checks++; if (o_val !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", o_val); end
        checks++; if (o_out !== 8'h00) begin errors++; $display("FAIL rst_out got=%h exp=00", o_out); end
        checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", o_rdy); end
        checks++; if (o_dep !== 8'd0) begin errors++; $display("FAIL rst_depth got=%0d exp=0", o_dep); end
        checks++; if (o_ok !== 1'b1) begin errors++; $display("FAIL rst_ok got=%b exp=1", o_ok); end
    endtask

    task automatic test_begin_end();
        string s;
        do_reset();
        cmdq = {3'b000, 3'b001};
        run_cmds(0);
        s = bytes_str();
        checks++; if (timeout) begin errors++; $display("FAIL be_timeout got=1 exp=0"); end
        checks++; if (s != "begin end ") begin errors++; $display("FAIL be_bytes got='%s' exp='begin end '", s); end
        checks++;
        if (got.size() != 10 || got_cyc[got.size()-1] - got_cyc[0] != 9) begin
            errors++; $display("FAIL be_gapless got=%0d bytes exp=10 consecutive", got.size());
        end
        checks++;
        if (got.size() < 7 || dep_at[6] !== 8'd1) begin
            errors++; $display("FAIL be_mid_depth got=%0d exp=1", got.size() < 7 ? -1 : int'(dep_at[6]));
        end
        checks++; if (o_dep !== 8'd0) begin errors++; $display("FAIL be_depth got=%0d exp=0", o_dep); end
        checks++; if (o_ok !== 1'b1) begin errors++; $display("FAIL be_ok got=%b exp=1", o_ok); end
    endtask

    task automatic test_back_to_back();
        string s;
        do_reset();
        cmdq = {3'b100, 3'b100};
        run_cmds(0);
        s = bytes_str();
        checks++; if (s != "BEGIN BEGIN ") begin errors++; $display("FAIL b2b_bytes got='%s' exp='BEGIN BEGIN '", s); end
        checks++;
        if (got.size() != 12 || got_cyc[got.size()-1] - got_cyc[0] != 11) begin
            errors++; $display("FAIL b2b_gapless got=%0d bytes exp=12 consecutive", got.size());
        end
        checks++; if (ready_bad != 0) begin errors++; $display("FAIL b2b_ready_on_letter got=%0d exp=0", ready_bad); end
        checks++; if (o_dep !== 8'd2) begin errors++; $display("FAIL b2b_depth got=%0d exp=2", o_dep); end
        checks++; if (o_ok !== 1'b0) begin errors++; $display("FAIL b2b_ok got=%b exp=0", o_ok); end
    endtask

    task automatic test_underflow();
        string s;
        do_reset();
        cmdq = {3'b001};
        run_cmds(0);
        s = bytes_str();
        checks++; if (s != "end ") begin errors++; $display("FAIL uf_bytes got='%s' exp='end '", s); end
        checks++; if (o_dep !== 8'd0) begin errors++; $display("FAIL uf_depth got=%0d exp=0", o_dep); end
        checks++; if (o_ok !== 1'b0) begin errors++; $display("FAIL uf_ok got=%b exp=0", o_ok); end
        cmdq = {3'b000, 3'b001};
        run_cmds(0);
        checks++; if (o_dep !== 8'd0) begin errors++; $display("FAIL uf_pair_depth got=%0d exp=0", o_dep); end
        checks++; if (o_ok !== 1'b0) begin errors++; $display("FAIL uf_sticky got=%b exp=0", o_ok); end
    endtask

    task automatic test_stall();
        string s;
        do_reset();
        cmdq = {3'b000};
        run_cmds(1);
        s = bytes_str();
        checks++; if (got.size() != 6) begin errors++; $display("FAIL st_count got=%0d exp=6", got.size()); end
        checks++; if (s != "begin ") begin errors++; $display("FAIL st_bytes got='%s' exp='begin '", s); end
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL st_hold got=%0d exp=0", hold_bad); end
        checks++; if (o_dep !== 8'd1) begin errors++; $display("FAIL st_depth got=%0d exp=1", o_dep); end
    endtask

    task automatic test_saturate();
        do_reset();
        cmdq = {3'b000, 3'b000, 3'b000, 3'b000};
        run_cmds(0);
        checks++; if (o_dep2 !== 2'd3) begin errors++; $display("FAIL sat_depth2 got=%0d exp=3", o_dep2); end
        checks++; if (o_ok2 !== 1'b0) begin errors++; $display("FAIL sat_ok2 got=%b exp=0", o_ok2); end
        checks++; if (o_dep !== 8'd4) begin errors++; $display("FAIL sat_depth8 got=%0d exp=4", o_dep); end
        cmdq = {3'b001, 3'b001, 3'b001};
        run_cmds(0);
        checks++; if (o_dep2 !== 2'd0) begin errors++; $display("FAIL sat_end_depth2 got=%0d exp=0", o_dep2); end
        checks++; if (o_ok2 !== 1'b0) begin errors++; $display("FAIL sat_end_ok2 got=%b exp=0", o_ok2); end
        checks++; if (o_dep !== 8'd1) begin errors++; $display("FAIL sat_end_depth8 got=%0d exp=1", o_dep); end
    endtask

    task automatic test_reset_midword();
        do_reset();
        cmdq = {3'b001, 3'b000};
        run_cmds(0);
        step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        checks++; if (o_out !== 8'h67) begin errors++; $display("FAIL mid_third got=%h exp=67", o_out); end
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        checks++; if (o_val !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", o_val); end
        checks++; if (o_dep !== 8'd0) begin errors++; $display("FAIL mid_depth got=%0d exp=0", o_dep); end
        checks++; if (o_ok !== 1'b1) begin errors++; $display("FAIL mid_ok got=%b exp=1", o_ok); end
        checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", o_rdy); end
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        checks++; if (o_val !== 1'b0) begin errors++; $display("FAIL mid_no_space got=%b exp=0", o_val); end
    endtask

    task automatic test_random();
        logic       cv, up, ordy, rst;
        logic [1:0] w;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cv   = 1'($urandom % 2);
            w    = 2'($urandom % 4);
            up   = 1'($urandom % 2);
            ordy = ($urandom % 4) != 0;
            rst  = ($urandom % 150) == 0;
            step(cv, w, up, ordy, rst);
            checks++; if (o_val !== e_val) begin errors++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, o_val, e_val); end
            checks++; if (o_out !== e_out) begin errors++; $display("FAIL rnd_out i=%0d got=%h exp=%h", i, o_out, e_out); end
            checks++; if (o_rdy !== e_rdy) begin errors++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, o_rdy, e_rdy); end
            checks++; if (o_dep !== e_dep) begin errors++; $display("FAIL rnd_depth i=%0d got=%0d exp=%0d", i, o_dep, e_dep); end
            checks++; if (o_ok !== e_ok) begin errors++; $display("FAIL rnd_ok i=%0d got=%b exp=%b", i, o_ok, e_ok); end
            checks++; if (o_out2 !== e_out || o_val2 !== e_val || o_rdy2 !== e_rdy) begin
                errors++; $display("FAIL rnd_stream2 i=%0d got=%h/%b/%b exp=%h/%b/%b", i, o_out2, o_val2, o_rdy2, e_out, e_val, e_rdy);
            end
            checks++; if (o_dep2 !== e_dep2) begin errors++; $display("FAIL rnd_depth2 i=%0d got=%0d exp=%0d", i, o_dep2, e_dep2); end
            checks++; if (o_ok2 !== e_ok2) begin errors++; $display("FAIL rnd_ok2 i=%0d got=%b exp=%b", i, o_ok2, e_ok2); end
        end
    endtask

    initial begin
        test_reset();
        test_begin_end();
        test_back_to_back();
        test_underflow();
        test_stall();
        test_saturate();
        test_reset_midword();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
